// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
//   Shared types and helpers for the mips_mem_initiator slice.
//   - mem_op_t : 3-bit load/store operation code seen on req_op.
//   - state_t  : initiator FSM states.
//   - size_t   : access width derived from the operation.
//   - is_store / op_size / is_misaligned / align_off helper functions.
//   No ports (package).
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic size_t op_size(input mem_op_t op);
        size_t sz;
        case (op)
            LB, LBU, SB: sz = SZ_BYTE;
            LH, LHU, SH: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        logic mis;
        case (op_size(op))
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Forces the byte offset to the natural alignment of the access width.
    function automatic logic [1:0] align_off(input mem_op_t op, input logic [1:0] off);
        logic [1:0] res;
        case (op_size(op))
            SZ_HALF: res = {off[1], 1'b0};
            SZ_WORD: res = 2'b00;
            default: res = off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips_load_align.sv
// ---------------------------------------------------------------------------
// mips_load_align
//   Combinational load-data lane select and sign/zero extension.
//   Memory is big-endian: byte offset 0 lives in word[31:24].
//   Ports:
//     op     in  3   mem_op_t of the load (non-load codes pass the word through)
//     off    in  2   byte offset inside the word (already aligned)
//     word   in  32  raw word read from memory
//     result out 32  extended load value
// ---------------------------------------------------------------------------
module mips_load_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // branch can leave it unassigned and infer a latch.
        byte_v = word[7:0];
        half_v = off[1] ? word[15:0] : word[31:16];
        result = word;

        case (off)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase

        case (mem_op_t'(op))
            LB:      result = {{24{byte_v[7]}}, byte_v};
            LBU:     result = {24'h0, byte_v};
            LH:      result = {{16{half_v[15]}}, half_v};
            LHU:     result = {16'h0, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mips_mem_initiator.sv
// ---------------------------------------------------------------------------
// mips_mem_initiator
//   CPU-side requester for the mips_memory bus. Takes one load/store at a
//   time over a valid/ready handshake, drives a single-cycle read or write
//   strobe, waits WAIT_CYCLES for the registered read port, and returns the
//   extended load data with a one-cycle resp_valid pulse.
//
//   Build option:
//     MIPS_MEM_MISALIGN_TRAP_EN defined   -> misaligned requests skip the
//         memory, answer directly with resp_err=1 and resp_rdata=0.
//     MIPS_MEM_MISALIGN_TRAP_EN undefined -> low address bits are forced to
//         natural alignment and the access proceeds; resp_err is tied 0.
//
//   Parameters:
//     ADDR_W      byte address width (request and memory)
//     WAIT_CYCLES memory read latency after the issue edge, 1..15
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     req_valid/req_ready         request handshake (ready only in IDLE)
//     req_op, req_addr, req_wdata request fields (wdata right-justified)
//     resp_valid                  one-cycle completion pulse
//     resp_rdata                  extended load data (0 for stores/traps)
//     resp_err                    misaligned trap, qualified by resp_valid
//     mem_active                  high whenever out of reset
//     mem_address                 word-aligned address, held between accepts
//     mem_wr_en / mem_read_en     single-cycle strobes in ISSUE
//     mem_byte_en                 lane enables, bit3 = byte offset 0
//     mem_data_in                 lane-replicated store data
//     mem_data_out                registered read data from memory
// ---------------------------------------------------------------------------
module mips_mem_initiator
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_active,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr_en,
    output logic              mem_read_en,
    output logic [3:0]        mem_byte_en,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              active_q;
    mem_op_t           op_q;
    logic [1:0]        off_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    mem_op_t           req_op_e;
    logic [1:0]        req_off;
    logic [3:0]        req_be;
    logic [31:0]       req_lane;
    logic              trap_hit;
    logic              accept;
    logic              store_q;
    logic [31:0]       load_result;

    // -----------------------------------------------------------------------
    // Request decode: effective offset, lane enables, replicated store data
    // -----------------------------------------------------------------------
    always_comb begin
        req_op_e = mem_op_t'(req_op);
        req_off  = align_off(req_op_e, req_addr[1:0]);
        req_be   = 4'b1111;
        req_lane = req_wdata;

        case (op_size(req_op_e))
            SZ_BYTE: begin
                req_be   = 4'b1000 >> req_off;
                req_lane = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_be   = req_off[1] ? 4'b0011 : 4'b1100;
                req_lane = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be   = 4'b1111;
                req_lane = req_wdata;
            end
        endcase

        // Loads present zero write data so the bus carries no stale value.
        if (!is_store(req_op_e)) begin
            req_lane = 32'h0;
        end
    end

`ifdef MIPS_MEM_MISALIGN_TRAP_EN
    assign trap_hit = is_misaligned(req_op_e, req_addr[1:0]);
`else
    assign trap_hit = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && active_q;
    assign accept    = req_valid && req_ready;
    assign store_q   = is_store(op_q);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = trap_hit ? RESP : ISSUE;
            ISSUE:   state_d = store_q ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            op_q     <= LB;
            off_q    <= 2'b00;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            active_q <= 1'b1;

            // Bus-facing fields only change on accept, so they stay stable
            // for the whole transaction and until the next one starts.
            if (accept) begin
                op_q    <= req_op_e;
                off_q   <= req_off;
                addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                be_q    <= req_be;
                wdata_q <= req_lane;
                rdata_q <= 32'h0;
            end

            case (state_q)
                ISSUE: begin
                    if (!store_q) cnt_q <= CNT_INIT;
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q <= load_result;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_MEM_MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= trap_hit;
        end
    end

    assign resp_err = (state_q == RESP) && err_q;
`else
    assign resp_err = 1'b0;
`endif

    mips_load_align u_load_align (
        .op     (op_q),
        .off    (off_q),
        .word   (mem_data_out),
        .result (load_result)
    );

    // -----------------------------------------------------------------------
    // Outputs: strobes decode from state, so reset drops them at once
    // -----------------------------------------------------------------------
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign mem_active  = active_q;
    assign mem_address = addr_q;
    assign mem_wr_en   = (state_q == ISSUE) && store_q;
    assign mem_read_en = (state_q == ISSUE) && !store_q;
    assign mem_byte_en = be_q;
    assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mips_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_initiator
//   Directed bench for mips_mem_initiator. Two instances share clk/rst_n:
//   u_dut (WAIT_CYCLES=1) and u_dut3 (WAIT_CYCLES=3), each with a small
//   big-endian byte-enabled memory responder with a registered read port.
// ---------------------------------------------------------------------------
module tb_mips_mem_initiator;
    import mips_mem_pkg::*;

    logic        clk;
    logic        rst_n;

    // u_dut signals
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_active;
    logic [31:0] mem_address;
    logic        mem_wr_en;
    logic        mem_read_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    // u_dut3 signals
    logic        r3_valid;
    logic        r3_ready;
    logic [2:0]  r3_op;
    logic [31:0] r3_addr;
    logic [31:0] r3_wdata;
    logic        r3_resp_valid;
    logic [31:0] r3_rdata;
    logic        r3_err;
    logic        m3_active;
    logic [31:0] m3_address;
    logic        m3_wr_en;
    logic        m3_read_en;
    logic [3:0]  m3_byte_en;
    logic [31:0] m3_data_in;
    logic [31:0] m3_data_out;

    int errors = 0;
    int checks = 0;

    // Per-transaction observations filled by txn()
    int          lat;
    int          n_wr;
    int          n_rd;
    int          n_both;
    logic [31:0] iss_addr;
    logic [3:0]  iss_be;
    logic [31:0] iss_data;
    logic [31:0] resp_addr;
    logic [31:0] got_rdata;
    logic        got_err;

    mips_mem_initiator #(.ADDR_W(32), .WAIT_CYCLES(1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_active   (mem_active),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_read_en  (mem_read_en),
        .mem_byte_en  (mem_byte_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    mips_mem_initiator #(.ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (r3_valid),
        .req_ready    (r3_ready),
        .req_op       (r3_op),
        .req_addr     (r3_addr),
        .req_wdata    (r3_wdata),
        .resp_valid   (r3_resp_valid),
        .resp_rdata   (r3_rdata),
        .resp_err     (r3_err),
        .mem_active   (m3_active),
        .mem_address  (m3_address),
        .mem_wr_en    (m3_wr_en),
        .mem_read_en  (m3_read_en),
        .mem_byte_en  (m3_byte_en),
        .mem_data_in  (m3_data_in),
        .mem_data_out (m3_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responders: registered read, byte-enabled write, bit3 = offset 0
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    always @(posedge clk) begin
        if (mem_read_en) mem_data_out <= mem_a[mem_address[7:2]];
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_en[b]) mem_a[mem_address[7:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (m3_read_en) m3_data_out <= mem_b[m3_address[7:2]];
        if (m3_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (m3_byte_en[b]) mem_b[m3_address[7:2]][8*b +: 8] <= m3_data_in[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction on u_dut; samples at negedges. lat counts
    // cycles after the accept edge until resp_valid (0 = never seen).
    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int guard;
        lat = 0; n_wr = 0; n_rd = 0; n_both = 0;
        got_rdata = 32'hDEAD_BEEF; got_err = 1'bx;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (mem_wr_en) n_wr++;
            if (mem_read_en) n_rd++;
            if (mem_wr_en && mem_read_en) n_both++;
            if (n == 1) begin
                iss_addr = mem_address;
                iss_be   = mem_byte_en;
                iss_data = mem_data_in;
            end
            if (resp_valid) begin
                lat       = n;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                resp_addr = mem_address;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [2:0]  t7_op   [0:2];
    logic [31:0] t7_addr [0:2];
    logic [31:0] t7_wd   [0:2];
    logic [15:0] v_ready, v_resp, v_wr, v_rd;
    logic [31:0] rd_c8, rd_c14;
    logic        seen_resp;

    initial begin
        req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        r3_valid  = 1'b0; r3_op  = 3'd0; r3_addr  = 32'h0; r3_wdata  = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        check("rst_ready",  32'(req_ready), 32'h0);
        check("rst_active", 32'(mem_active), 32'h0);
        check("rst_outs",   32'(|{resp_valid, resp_rdata, resp_err, mem_address,
                                   mem_wr_en, mem_read_en, mem_byte_en, mem_data_in}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready",  32'(req_ready), 32'h1);
        check("post_rst_active", 32'(mem_active), 32'h1);

        // ---- 1: SW then LW at 0x08 ----
        txn(SW, 32'h08, 32'h0000_004F);
        check("sw_lat",    lat, 2);
        check("sw_wr_cnt", n_wr, 1);
        check("sw_rd_cnt", n_rd, 0);
        check("sw_be",     32'(iss_be), 32'hF);
        check("sw_addr",   iss_addr, 32'h08);
        check("sw_data",   iss_data, 32'h0000_004F);
        check("sw_rdata",  got_rdata, 32'h0);
        check("sw_addr_stable", resp_addr, 32'h08);
        txn(LW, 32'h08, 32'h0);
        check("lw_lat",    lat, 3);
        check("lw_rd_cnt", n_rd, 1);
        check("lw_wr_cnt", n_wr, 0);
        check("lw_rdata",  got_rdata, 32'h0000_004F);
        check("lw_err",    32'(got_err), 32'h0);

        // ---- 2: extension from word 0x80FF7F01 at 0x10 ----
        txn(SW, 32'h10, 32'h80FF_7F01);
        txn(LB,  32'h10, 32'h0); check("lb_10",  got_rdata, 32'hFFFF_FF80);
        txn(LBU, 32'h11, 32'h0); check("lbu_11", got_rdata, 32'h0000_00FF);
        txn(LB,  32'h12, 32'h0); check("lb_12",  got_rdata, 32'h0000_007F);
        txn(LB,  32'h13, 32'h0); check("lb_13",  got_rdata, 32'h0000_0001);
        txn(LH,  32'h12, 32'h0); check("lh_12",  got_rdata, 32'h0000_7F01);
        txn(LHU, 32'h10, 32'h0); check("lhu_10", got_rdata, 32'h0000_80FF);
        txn(LH,  32'h10, 32'h0); check("lh_10",  got_rdata, 32'hFFFF_80FF);
        check("lh_10_both", n_both, 0);

        // ---- 3: sub-word stores and merge ----
        txn(SW, 32'h20, 32'h1122_3344);
        txn(SB, 32'h23, 32'h0000_00AB);
        check("sb_be",   32'(iss_be), 32'h1);
        check("sb_data", iss_data, 32'hABAB_ABAB);
        check("sb_addr", iss_addr, 32'h20);
        txn(SH, 32'h22, 32'h0000_1234);
        check("sh_be",   32'(iss_be), 32'h3);
        check("sh_data", iss_data, 32'h1234_1234);
        txn(LW, 32'h20, 32'h0);
        check("merge_lw", got_rdata, 32'h1122_1234);

        // ---- 4/5: misaligned word load ----
        txn(SW, 32'h04, 32'hCAFE_F00D);
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
        txn(LW, 32'h05, 32'h0);
        check("trap_lat",    lat, 1);
        check("trap_err",    32'(got_err), 32'h1);
        check("trap_rdata",  got_rdata, 32'h0);
        check("trap_strobe", n_wr + n_rd, 0);
        txn(LW, 32'h04, 32'h0);
        check("aligned_err", 32'(got_err), 32'h0);
`else
        txn(LW, 32'h05, 32'h0);
        check("mis_lw_addr",  iss_addr, 32'h04);
        check("mis_lw_rdata", got_rdata, 32'hCAFE_F00D);
        check("mis_lw_err",   32'(got_err), 32'h0);
        check("mis_lw_lat",   lat, 3);
        txn(LH, 32'h13, 32'h0);
        check("mis_lh_addr",  iss_addr, 32'h10);
        check("mis_lh_rdata", got_rdata, 32'h0000_7F01);
`endif

        // ---- 6: reset during WAIT of a load ----
        @(negedge clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);          // ISSUE
        req_valid = 1'b0;
        check("rst6_issue_rd", 32'(mem_read_en), 32'h1);
        @(negedge clk);          // WAIT
        #1 rst_n = 1'b0;
        #1;
        check("rst6_outs", 32'(|{req_ready, resp_valid, resp_rdata, resp_err, mem_active,
                                  mem_address, mem_wr_en, mem_read_en, mem_byte_en, mem_data_in}), 32'h0);
        seen_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (resp_valid) seen_resp = 1'b1;
        check("rst6_no_resp", 32'(seen_resp), 32'h0);
        check("rst6_ready",   32'(req_ready), 32'h1);
        check("rst6_active",  32'(mem_active), 32'h1);
        txn(SW, 32'h30, 32'h0000_5A5A);
        check("rst6_sw_lat", lat, 2);
        check("rst6_sw_wr",  n_wr, 1);
        txn(LW, 32'h30, 32'h0);
        check("rst6_lw", got_rdata, 32'h0000_5A5A);

        // ---- 7: WAIT_CYCLES=3, back-to-back valid on u_dut3 ----
        t7_op[0] = SW;  t7_addr[0] = 32'h10; t7_wd[0] = 32'h80FF_7F01;
        t7_op[1] = LW;  t7_addr[1] = 32'h10; t7_wd[1] = 32'h0;
        t7_op[2] = LBU; t7_addr[2] = 32'h11; t7_wd[2] = 32'h0;
        v_ready = '0; v_resp = '0; v_wr = '0; v_rd = '0;
        rd_c8 = '0; rd_c14 = '0;
        begin
            int  idx;
            logic prev_acc;
            idx = 0;
            prev_acc = 1'b0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (c == 0 || prev_acc) begin
                    if (prev_acc) idx++;
                    if (idx < 3) begin
                        r3_valid = 1'b1;
                        r3_op    = t7_op[idx];
                        r3_addr  = t7_addr[idx];
                        r3_wdata = t7_wd[idx];
                    end else begin
                        r3_valid = 1'b0;
                    end
                end
                v_ready[c] = r3_ready;
                v_resp[c]  = r3_resp_valid;
                v_wr[c]    = m3_wr_en;
                v_rd[c]    = m3_read_en;
                if (c == 8)  rd_c8  = r3_rdata;
                if (c == 14) rd_c14 = r3_rdata;
                prev_acc = r3_ready && r3_valid;
            end
            r3_valid = 1'b0;
        end
        check("b2b_ready",  32'(v_ready), 32'h0000_8209);
        check("b2b_resp",   32'(v_resp),  32'h0000_4104);
        check("b2b_wr",     32'(v_wr),    32'h0000_0002);
        check("b2b_rd",     32'(v_rd),    32'h0000_0410);
        check("b2b_lw",     rd_c8,        32'h80FF_7F01);
        check("b2b_lbu",    rd_c14,       32'h0000_00FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
